lead_one_mult_ctrl: RTL and testbench
=====================================

LEAD_ONE_MULT_CTRL -- requirements
Module: lead_one_mult_ctrl

Interface
REQ-001 Parameter WIDTH, 8: operand width in bits (>=2).
REQ-002 Parameter PAIRS, 4: operand pairs per run (>=1).
REQ-003 Parameter ADDR_W, 8: memory address width (>= clog2(2*PAIRS)).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstN  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin run; sampled only in IDLE.
REQ-007 abort  in  1  terminate run; effective in any state except IDLE.
REQ-008 memAck  in  1  memory handshake acknowledge for the current readMem/writeMem request.
REQ-009 msbA, msbB  in  1 each  current MSB of the datapath A/B shift registers.
REQ-010 readMem, writeMem  out  1 each  memory request, held until memAck.
REQ-011 rdAddr, wrAddr  out  ADDR_W each  read and write addresses.
REQ-012 storeA, storeB, storeR  out  1 each  one-cycle load strobes.
REQ-013 shiftA, shiftB, shiftR  out  1 each  one-shift-per-cycle strobes.
REQ-014 zeroRes  out  1  force written result to zero; valid while writeMem=1.
REQ-015 busy  out  1  high in every state except IDLE; done  out  1  one-cycle run-complete pulse; aborted  out  1  one-cycle abort pulse.

Function
REQ-016 States: IDLE, RDA, LDA, NORMA, RDB, LDB, NORMB, MUL, DEN, WR, DONE.
REQ-017 Internal: pairIdx (0..PAIRS-1), cntA/cntB (0..WIDTH-1), zeroA/zeroB flags, denCnt (0..2*WIDTH-2).
REQ-018 IDLE: start=1 -> RDA, clears pairIdx, cntA, cntB, zeroA, zeroB; start=0 -> stay.
REQ-019 RDA: readMem=1, rdAddr=2*pairIdx; memAck=1 -> LDA, else stay with rdAddr stable.
REQ-020 LDA: storeA=1 for exactly one cycle -> NORMA; cntA and zeroA cleared.
REQ-021 NORMA: msbA=1 -> RDB; else cntA=WIDTH-1 -> zeroA=1, RDB; else shiftA=1, cntA+1, stay.
REQ-022 RDB/LDB/NORMB mirror RDA/LDA/NORMA using rdAddr=2*pairIdx+1, storeB, shiftB, msbB, cntB, zeroB.
REQ-023 NORMB exit: zeroA or zeroB (including zeroB set in the exit cycle) -> WR with zeroRes=1; else -> MUL.
REQ-024 MUL: storeR=1 one cycle; denCnt loaded with cntA+cntB -> DEN.
REQ-025 DEN: denCnt!=0 -> shiftR=1, denCnt-1, stay; denCnt=0 -> WR; exactly cntA+cntB shiftR pulses.
REQ-026 WR: writeMem=1, wrAddr=pairIdx, held until memAck; on memAck: pairIdx=PAIRS-1 -> DONE, else pairIdx+1 -> RDA.
REQ-027 DONE: done=1 one cycle -> IDLE.
REQ-028 memAck is accepted in the same cycle the request first rises; it is ignored outside RDA, RDB and WR.
REQ-029 Per-pair latency with zero-wait memAck, nonzero operands: 9+2*(cntA+cntB) cycles.
REQ-030 abort=1 in any non-IDLE state: next state IDLE, aborted=1 next cycle, no done, no further strobes; abort has priority over memAck and every other transition.
REQ-031 start while busy ignored; abort in IDLE ignored.
REQ-032 All strobes mutually exclusive; every output is a function of state plus the listed inputs.

Reset
REQ-033 rstN=0 forces IDLE immediately; pairIdx, counters, and flags cleared; every output 0 (addresses 0) while rstN=0 and in the first cycle after release.
REQ-034 Reset mid-run discards the run; no done or aborted pulse is produced.

Verification (WIDTH=8, PAIRS=2, memAck=1 whenever requested, unless noted)
REQ-035 Pair0: A=0x10, B=0x80 -> 3 shiftA, 0 shiftB, storeR once, 3 shiftR, writeMem at wrAddr=0 with zeroRes=0, pair length 15 cycles.
REQ-036 Pair1: A=0x00, B=0x05 -> 7 shiftA with zeroA set; B still normalised (5 shiftB); no storeR or shiftR; writeMem at wrAddr=1 with zeroRes=1; then done pulses once and busy falls.
REQ-037 memAck delayed 3 cycles in RDB -> readMem high 4 cycles, rdAddr=1 stable, storeB exactly one cycle after the ack cycle.
REQ-038 abort during DEN after 1 of 3 shiftR -> aborted one cycle, no writeMem; next start restarts at rdAddr=0.
REQ-039 rstN low during NORMA -> all outputs 0 asynchronously; after release with start=1 the run restarts at pairIdx=0.
REQ-040 start pulsed while busy -> no effect on state, addresses, or pair count.

Source files
------------

// File: rtl/lead_one_mult_ctrl.sv
// Control FSM for a leading-one normalising multiplier. For each operand pair
// it fetches A and B from memory, shifts each left until its MSB is set
// (counting shifts), triggers the product load, shifts the product back right
// by the total normalisation count, and writes the result out. Zero operands
// skip the multiply and force a zero result.
module lead_one_mult_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PAIRS  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              abort,
  input  logic              memAck,
  input  logic              msbA,
  input  logic              msbB,
  output logic              readMem,
  output logic              writeMem,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              storeA,
  output logic              storeB,
  output logic              storeR,
  output logic              shiftA,
  output logic              shiftB,
  output logic              shiftR,
  output logic              zeroRes,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DEN_W = $clog2(2*WIDTH-1);
  localparam int PI_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic [3:0] {
    IDLE, RDA, LDA, NORMA, RDB, LDB, NORMB, MUL, DEN, WR, DONE
  } state_t;

  state_t           state;
  logic [PI_W-1:0]  pairIdx;
  logic [CNT_W-1:0] cntA, cntB;
  logic             zeroA, zeroB;
  logic [DEN_W-1:0] denCnt;
  logic             abortedQ;

  // Sequencing, counters and flags; abort outranks every other transition.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      pairIdx  <= '0;
      cntA     <= '0;
      cntB     <= '0;
      zeroA    <= 1'b0;
      zeroB    <= 1'b0;
      denCnt   <= '0;
      abortedQ <= 1'b0;
    end else begin
      abortedQ <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        abortedQ <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            pairIdx <= '0;
            cntA    <= '0;
            cntB    <= '0;
            zeroA   <= 1'b0;
            zeroB   <= 1'b0;
            state   <= RDA;
          end
          RDA: if (memAck) state <= LDA;
          LDA: begin
            cntA  <= '0;
            zeroA <= 1'b0;
            state <= NORMA;
          end
          NORMA: begin
            if (msbA) state <= RDB;
            else if (cntA == CNT_W'(WIDTH-1)) begin
              zeroA <= 1'b1;
              state <= RDB;
            end else cntA <= cntA + 1'b1;
          end
          RDB: if (memAck) state <= LDB;
          LDB: begin
            cntB  <= '0;
            zeroB <= 1'b0;
            state <= NORMB;
          end
          NORMB: begin
            if (msbB) state <= (zeroA || zeroB) ? WR : MUL;
            else if (cntB == CNT_W'(WIDTH-1)) begin
              // B is zero: the result is zero whatever A was
              zeroB <= 1'b1;
              state <= WR;
            end else cntB <= cntB + 1'b1;
          end
          MUL: begin
            denCnt <= DEN_W'(cntA) + DEN_W'(cntB);
            state  <= DEN;
          end
          DEN: begin
            if (denCnt != '0) denCnt <= denCnt - 1'b1;
            else state <= WR;
          end
          WR: if (memAck) begin
            if (pairIdx == PI_W'(PAIRS-1)) state <= DONE;
            else begin
              pairIdx <= pairIdx + 1'b1;
              state   <= RDA;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output decode from state; strobes are mutually exclusive by construction.
  always_comb begin
    readMem  = (state == RDA) || (state == RDB);
    writeMem = (state == WR);
    rdAddr   = '0;
    wrAddr   = '0;
    if (readMem)  rdAddr = (ADDR_W'(pairIdx) << 1) | ADDR_W'(state == RDB);
    if (writeMem) wrAddr = ADDR_W'(pairIdx);
    storeA   = (state == LDA);
    storeB   = (state == LDB);
    storeR   = (state == MUL);
    shiftA   = (state == NORMA) && !msbA && (cntA != CNT_W'(WIDTH-1));
    shiftB   = (state == NORMB) && !msbB && (cntB != CNT_W'(WIDTH-1));
    shiftR   = (state == DEN) && (denCnt != '0);
    zeroRes  = writeMem && (zeroA || zeroB);
    busy     = (state != IDLE);
    done     = (state == DONE);
    aborted  = abortedQ;
  end

endmodule

// File: tb/tb_lead_one_mult_ctrl.sv
// Directed bench for lead_one_mult_ctrl (WIDTH=8, PAIRS=2) with a small
// memory and A/B shift-register model closing the msb feedback loop.
module tb_lead_one_mult_ctrl;
  localparam int WIDTH = 8, PAIRS = 2, ADDR_W = 8;

  logic clk = 0, rstN, start, abort, memAck, msbA, msbB;
  logic readMem, writeMem, storeA, storeB, storeR, shiftA, shiftB, shiftR;
  logic zeroRes, busy, done, aborted;
  logic [ADDR_W-1:0] rdAddr, wrAddr;

  lead_one_mult_ctrl #(.WIDTH(WIDTH), .PAIRS(PAIRS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort), .memAck(memAck),
    .msbA(msbA), .msbB(msbB), .readMem(readMem), .writeMem(writeMem),
    .rdAddr(rdAddr), .wrAddr(wrAddr), .storeA(storeA), .storeB(storeB),
    .storeR(storeR), .shiftA(shiftA), .shiftB(shiftB), .shiftR(shiftR),
    .zeroRes(zeroRes), .busy(busy), .done(done), .aborted(aborted));

  always #5 clk = ~clk;

  // memory + datapath model
  logic [7:0] mem [4];
  logic [7:0] rdData, regA, regB;
  assign msbA = regA[7];
  assign msbB = regB[7];
  always @(posedge clk) begin
    if (readMem && memAck) rdData <= mem[rdAddr[1:0]];
    if (storeA) regA <= rdData; else if (shiftA) regA <= regA << 1;
    if (storeB) regB <= rdData; else if (shiftB) regB <= regB << 1;
  end

  // monitor / ack responder state
  int cyc = 0, rdbDelay = 0, rdbWait = 0, exclBad = 0;
  int nDone, nAborted, nWr, nShA, nShR, firstRd;
  bit seenRd, inPair;
  int len, cShA, cShB, cStR, cShR, cRdB, cAckB, cStB;
  bit cRdBBad;
  logic [ADDR_W-1:0] cRdBAddr;
  int rShA[2], rShB[2], rStR[2], rShR[2], rLen[2], rRdB[2], rAckB[2], rStB[2];
  bit rZero[2], rRdBBad[2];

  always @(negedge clk) begin
    cyc++;
    if (readMem && rdAddr[0]) rdbWait++; else rdbWait = 0;
    memAck = (readMem || writeMem) && !(readMem && rdAddr[0] && rdbWait <= rdbDelay);
    if ($countones({readMem, writeMem, storeA, storeB, storeR, shiftA, shiftB, shiftR, done}) > 1)
      exclBad++;
    if (start && !busy) begin
      nDone = 0; nAborted = 0; nWr = 0; nShA = 0; nShR = 0; seenRd = 0; inPair = 0;
    end
    if (readMem && !seenRd) begin firstRd = int'(rdAddr); seenRd = 1; end
    if (readMem && !rdAddr[0] && !inPair) begin
      inPair = 1; len = 0; cShA = 0; cShB = 0; cStR = 0; cShR = 0;
      cRdB = 0; cAckB = -1; cStB = -1; cRdBBad = 0;
    end
    if (inPair) len++;
    if (readMem && rdAddr[0]) begin
      if (cRdB == 0) cRdBAddr = rdAddr; else if (rdAddr != cRdBAddr) cRdBBad = 1;
      cRdB++;
      if (memAck) cAckB = cyc;
    end
    if (storeB && cStB < 0) cStB = cyc;
    if (shiftA) begin cShA++; nShA++; end
    if (shiftB) cShB++;
    if (storeR) cStR++;
    if (shiftR) begin cShR++; nShR++; end
    if (done) nDone++;
    if (aborted) nAborted++;
    if (writeMem) nWr++;
    if (writeMem && memAck && wrAddr < 2) begin
      rShA[wrAddr[0]] = cShA; rShB[wrAddr[0]] = cShB; rStR[wrAddr[0]] = cStR;
      rShR[wrAddr[0]] = cShR; rLen[wrAddr[0]] = len; rZero[wrAddr[0]] = zeroRes;
      rRdB[wrAddr[0]] = cRdB; rAckB[wrAddr[0]] = cAckB; rStB[wrAddr[0]] = cStB;
      rRdBBad[wrAddr[0]] = cRdBBad;
      inPair = 0;
    end
  end

  int vecs = 0, miscmp = 0;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outsAll();
    return int'({readMem, writeMem, storeA, storeB, storeR, shiftA, shiftB, shiftR,
                 zeroRes, busy, done, aborted}) | int'(rdAddr) | int'(wrAddr);
  endfunction

  // launch a run and wait for done; optionally pulse start mid-run
  task automatic runTask(input bit midStart);
    bit ok = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (midStart && i == 10) start = 1;
      if (midStart && i == 11) start = 0;
      if (nDone > 0) begin ok = 1; break; end
    end
    chk("run_timeout", int'(ok), 1);
    @(negedge clk); #1;
    chk("busy_after_done", int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] a, b;
    int shA, shB, stR, shR, zero, len;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{8'h10, 8'h80, 3, 0, 1, 3, 0, 15};
    tbl[1] = '{8'h00, 8'h05, 7, 5, 0, 0, 1, 19};
    tbl[2] = '{8'h01, 8'h40, 7, 1, 1, 8, 0, 25};
    tbl[3] = '{8'hFF, 8'h00, 0, 7, 0, 0, 1, 14};
    rstN = 0; start = 0; abort = 0;
    #1 chk("reset_outs", outsAll(), 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1;
    @(negedge clk); #1 chk("post_release_outs", outsAll(), 0);

    // table runs; second run also pulses start while busy
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) begin mem[2*k] = tbl[2*r+k].a; mem[2*k+1] = tbl[2*r+k].b; end
      runTask(r == 1);
      chk("done_count", nDone, 1);
      chk("aborted_count", nAborted, 0);
      chk("first_rdAddr", firstRd, 0);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("r%0dp%0d_shiftA", r, p), rShA[p], tbl[2*r+p].shA);
        chk($sformatf("r%0dp%0d_shiftB", r, p), rShB[p], tbl[2*r+p].shB);
        chk($sformatf("r%0dp%0d_storeR", r, p), rStR[p], tbl[2*r+p].stR);
        chk($sformatf("r%0dp%0d_shiftR", r, p), rShR[p], tbl[2*r+p].shR);
        chk($sformatf("r%0dp%0d_zeroRes", r, p), int'(rZero[p]), tbl[2*r+p].zero);
        chk($sformatf("r%0dp%0d_len", r, p), rLen[p], tbl[2*r+p].len);
      end
    end

    // delayed ack in RDB
    mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'h00; mem[3] = 8'h05;
    rdbDelay = 3;
    runTask(0);
    rdbDelay = 0;
    chk("dly_readMem_cycles", rRdB[0], 4);
    chk("dly_rdAddr_stable", int'(rRdBBad[0]), 0);
    chk("dly_storeB_after_ack", rStB[0] - rAckB[0], 1);
    chk("dly_shiftR", rShR[0], 3);
    chk("dly_done", nDone, 1);

    // abort in DEN after the first shiftR
    begin
      bit hit = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (nShR >= 1) begin hit = 1; break; end
      end
      chk("abort_reach_den", int'(hit), 1);
      abort = 1;
      @(posedge clk); #1 abort = 0;
      repeat (6) @(negedge clk);
      #1;
      chk("abort_pulses", nAborted, 1);
      chk("abort_shiftR", nShR, 1);
      chk("abort_no_write", nWr, 0);
      chk("abort_no_done", nDone, 0);
      chk("abort_idle", int'(busy), 0);
    end
    runTask(0);
    chk("post_abort_first_rd", firstRd, 0);
    chk("post_abort_done", nDone, 1);
    chk("post_abort_len0", rLen[0], 15);

    // reset during NORMA
    begin
      bit hit = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (nShA >= 1) begin hit = 1; break; end
      end
      chk("rst_reach_norma", int'(hit), 1);
      rstN = 0;
      #1 chk("rst_async_outs", outsAll(), 0);
      repeat (2) @(posedge clk);
      #1 rstN = 1;
      @(negedge clk); #1 chk("rst_release_outs", outsAll(), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_no_done", nDone, 0);
      chk("rst_no_aborted", nAborted, 0);
    end
    runTask(0);
    chk("post_rst_first_rd", firstRd, 0);
    chk("post_rst_done", nDone, 1);
    chk("post_rst_len0", rLen[0], 15);
    chk("post_rst_zero1", int'(rZero[1]), 1);

    chk("strobe_exclusive", exclBad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
